// File: rtl/memory_system_pkg.sv
// rtl/memory_system_pkg.sv - shared state enum, word width and default depths for memory_system
package memory_system_pkg;

    localparam int WORD_W         = 16;
    localparam int DEF_IMEM_DEPTH = 256;
    localparam int DEF_DMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/memory_system_sp_ram.sv
// rtl/memory_system_sp_ram.sv - single-port RAM with one synchronous write port and async read
module sp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read sees the old word during a same-cycle write.
    assign rdata = mem[addr];

endmodule

// File: rtl/memory_system.sv
// rtl/memory_system.sv - imem/dmem pair with clear, program-load and run sequencing
// Optional access checker (mem_err output) enabled by defining MEM_ACCESS_CHECK_EN.
module memory_system
    import memory_system_pkg::*;
#(
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] instrAddr,
    output logic [WORD_W-1:0] instruction,
    input  logic [WORD_W-1:0] dataAddr,
    input  logic [WORD_W-1:0] datain,
    input  logic              MemRd,
    input  logic              MemWr,
    output logic [WORD_W-1:0] dataout,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold
`ifdef MEM_ACCESS_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    state_t            state;
    logic [DAW-1:0]    clr_cnt;
    logic [IAW-1:0]    load_ptr;

    logic              imem_we;
    logic [IAW-1:0]    imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              dmem_we;
    logic [DAW-1:0]    dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic [IAW-1:0]    instr_idx;
    logic [DAW-1:0]    data_idx;
    logic              beat;

    assign instr_idx = IAW'(32'(instrAddr) % IMEM_DEPTH);
    assign data_idx  = DAW'(32'(dataAddr) % DMEM_DEPTH);
    assign beat      = (state == LOAD) && load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            load_ptr   <= '0;
            load_ready <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == DAW'(DMEM_DEPTH - 1)) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        load_ptr <= load_ptr + 1'b1;
                        // A full image ends the load even without load_last.
                        if (load_last || load_ptr == IAW'(IMEM_DEPTH - 1)) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            cpu_hold   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state      <= CLEAR;
                    clr_cnt    <= '0;
                    load_ptr   <= '0;
                    load_ready <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_we    = !reset && beat;
    assign imem_addr  = (state == LOAD) ? load_ptr : instr_idx;
    assign dmem_we    = !reset && ((state == CLEAR) || ((state == RUN) && MemWr));
    assign dmem_addr  = (state == CLEAR) ? clr_cnt : data_idx;
    assign dmem_wdata = (state == CLEAR) ? '0 : datain;

    sp_ram #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (WORD_W)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .addr  (imem_addr),
        .wdata (load_data),
        .rdata (imem_rdata)
    );

    sp_ram #(
        .DEPTH (DMEM_DEPTH),
        .WIDTH (WORD_W)
    ) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    assign instruction = (state == RUN) ? imem_rdata : '0;
    assign dataout     = ((state == RUN) && MemRd) ? dmem_rdata : '0;

`ifdef MEM_ACCESS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if ((state == RUN) &&
                     (((MemRd || MemWr) && (32'(dataAddr) >= DMEM_DEPTH)) ||
                      (32'(instrAddr) >= IMEM_DEPTH) ||
                      (MemRd && MemWr))) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_system.sv
// tb/tb_memory_system.sv - self-checking bench for memory_system against an array-based reference model
module tb_memory_system;

    localparam int ID = 256;
    localparam int DD = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instrAddr;
    logic [15:0] instruction;
    logic [15:0] dataAddr;
    logic [15:0] datain;
    logic        MemRd;
    logic        MemWr;
    logic [15:0] dataout;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_hold;
`ifdef MEM_ACCESS_CHECK_EN
    logic        mem_err;
`endif

    memory_system #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
        .clk         (clk),
        .reset       (reset),
        .instrAddr   (instrAddr),
        .instruction (instruction),
        .dataAddr    (dataAddr),
        .datain      (datain),
        .MemRd       (MemRd),
        .MemWr       (MemWr),
        .dataout     (dataout),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_hold    (cpu_hold)
`ifdef MEM_ACCESS_CHECK_EN
        ,
        .mem_err     (mem_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] imem_m [ID];
    logic [15:0] dmem_m [DD];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(output int n, output int bad_hold);
        n = 0;
        bad_hold = 0;
        while (!load_ready && n < 2000) begin
            if (cpu_hold !== 1'b1) bad_hold++;
            n++;
            tick();
        end
    endtask

    task automatic load_beat(input logic [15:0] d, input bit last, input int idx, output bit hold_seen);
        int g;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        g = 0;
        #1;
        while (!load_ready && g < 50) begin
            tick();
            g++;
        end
        chk("load_beat_ready", load_ready, 1'b1);
        hold_seen = cpu_hold;
        imem_m[idx] = d;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bh, ptr, guard, lr_drop, bad;
        bit v, hs;
        logic [15:0] w, a, ia;
        logic [15:0] fa [7];

        vt[0] = '{1'b1, 1'b0, 16'd5,      16'hBEEF, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 16'd5,      16'h0000, 16'hBEEF};
        vt[2] = '{1'b0, 1'b0, 16'd5,      16'h0000, 16'h0000};
        vt[3] = '{1'b1, 1'b1, 16'd7,      16'h1234, 16'h0000};
        vt[4] = '{1'b0, 1'b1, 16'd7,      16'h0000, 16'h1234};
        vt[5] = '{1'b1, 1'b0, 16'h0105,   16'hCAFE, 16'h0000};
        vt[6] = '{1'b0, 1'b1, 16'd5,      16'h0000, 16'hCAFE};
        fa[0] = 16'd0; fa[1] = 16'd1; fa[2] = 16'd127; fa[3] = 16'd255;
        fa[4] = 16'd256; fa[5] = 16'h01FF; fa[6] = 16'hFFFF;

        reset = 1'b1; instrAddr = '0; dataAddr = '0; datain = '0;
        MemRd = 1'b0; MemWr = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < DD; i++) dmem_m[i] = '0;

        // CLEAR phase, with accesses that must be ignored
        MemRd = 1'b1; instrAddr = 16'd3;
        #1;
        chk("reset_cpu_hold", cpu_hold, 1'b1);
        chk("reset_load_ready", load_ready, 1'b0);
        chk("clear_dataout", dataout, 16'h0);
        chk("clear_instruction", instruction, 16'h0);
        MemRd = 1'b0;
        wait_clear(n, bh);
        chk("clear_cycles", n, 256);
        chk("clear_hold", bh, 0);
        chk("load_hold", cpu_hold, 1'b1);

        // Full image with random gaps; the last slot ends LOAD without load_last
        ptr = 0; guard = 0; lr_drop = 0;
        while (ptr < ID && guard < 3000) begin
            v = ($urandom_range(0, 3) != 0);
            w = 16'($urandom);
            load_valid = v; load_data = w; load_last = 1'b0;
            #1;
            if (load_ready !== 1'b1) lr_drop++;
            if (v && load_ready) begin
                imem_m[ptr] = w;
                ptr++;
            end
            tick();
            guard++;
        end
        load_valid = 1'b0;
        #1;
        chk("full_load_ready_steady", lr_drop, 0);
        chk("full_load_run_hold", cpu_hold, 1'b0);
        chk("full_load_run_ready", load_ready, 1'b0);

        load_valid = 1'b1; load_data = ~imem_m[0];
        #1;
        chk("run_beat_ready", load_ready, 1'b0);
        tick();
        load_valid = 1'b0;

        MemRd = 1'b1;
        bad = 0;
        for (int i = 0; i < DD; i++) begin
            dataAddr = 16'(i);
            #1;
            if (dataout !== 16'h0) bad++;
        end
        chk("dmem_cleared", bad, 0);
        MemRd = 1'b0;

        for (int i = 0; i < 7; i++) begin
            instrAddr = fa[i];
            #1;
            chk("fetch", instruction, imem_m[fa[i] % ID]);
        end

        // Table-driven data port vectors
        for (int i = 0; i < 7; i++) begin
            MemWr = vt[i].wr; MemRd = vt[i].rd; dataAddr = vt[i].addr; datain = vt[i].din;
            #1;
            chk("vec_dataout", dataout, vt[i].exp);
            if (vt[i].wr) dmem_m[vt[i].addr % DD] = vt[i].din;
            tick();
        end
        MemWr = 1'b0; MemRd = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            v  = $urandom_range(0, 1);
            MemWr = $urandom_range(0, 1);
            MemRd = v;
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            ia = 16'($urandom);
            dataAddr = a; instrAddr = ia; datain = 16'($urandom);
            #1;
            chk("rand_dataout", dataout, v ? dmem_m[a % DD] : 16'h0);
            chk("rand_instruction", instruction, imem_m[ia % ID]);
            if (MemWr) dmem_m[a % DD] = datain;
            tick();
        end
        MemWr = 1'b0; MemRd = 1'b0;

        // Reset from RUN, then again mid-CLEAR
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instrAddr = 16'd0;
        #1;
        chk("run_reset_hold", cpu_hold, 1'b1);
        chk("run_reset_instruction", instruction, 16'h0);
        for (int i = 0; i < DD; i++) dmem_m[i] = '0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear(n, bh);
        chk("midclear_reset_cycles", n, 256);

        // Reset mid-LOAD after two beats
        load_beat(16'hAAAA, 1'b0, 0, hs);
        load_beat(16'hBBBB, 1'b0, 1, hs);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midload_reset_ready", load_ready, 1'b0);
        chk("midload_reset_hold", cpu_hold, 1'b1);
        wait_clear(n, bh);
        chk("midload_reclear_cycles", n, 256);

        load_beat(16'h1111, 1'b0, 0, hs);
        load_beat(16'h2222, 1'b0, 1, hs);
        load_beat(16'h3333, 1'b1, 2, hs);
        chk("last_beat_hold", hs, 1'b1);
        chk("after_last_hold", cpu_hold, 1'b0);
        chk("after_last_ready", load_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            instrAddr = 16'(i);
            #1;
            chk("reload_fetch", instruction, imem_m[i]);
        end
        MemRd = 1'b1; dataAddr = 16'd5;
        #1;
        chk("reclear_dmem5", dataout, 16'h0);
        MemRd = 1'b0;

        // Out-of-range data address
        MemWr = 1'b1; dataAddr = 16'd0; datain = 16'h5A5A; instrAddr = 16'd0;
        tick();
        MemWr = 1'b0;
`ifdef MEM_ACCESS_CHECK_EN
        chk("err_idle", mem_err, 1'b0);
        MemRd = 1'b1; dataAddr = 16'h0100;
        #1;
        chk("err_same_cycle", mem_err, 1'b0);
        tick();
        MemRd = 1'b0; dataAddr = 16'd0;
        #1;
        chk("err_set", mem_err, 1'b1);
        repeat (5) tick();
        chk("err_sticky", mem_err, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("err_reset", mem_err, 1'b0);
`else
        MemRd = 1'b1; dataAddr = 16'h0100;
        #1;
        chk("wrap_read", dataout, 16'h5A5A);
        MemRd = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
